// File: rtl/axi_lite_arb2.sv
// Two-master AXI4-Lite arbiter in front of the peripheral bridge. One transaction
// (read or write) is outstanding on the slave side at a time; round-robin between masters.
module axi_lite_arb2 #(
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    // master 0
    input  logic [31:0] m0_araddr,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [31:0] m0_rdata,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    input  logic [31:0] m0_awaddr,
    input  logic        m0_awvalid,
    output logic        m0_awready,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    input  logic        m0_wvalid,
    output logic        m0_wready,
    output logic        m0_bvalid,
    input  logic        m0_bready,
    // master 1
    input  logic [31:0] m1_araddr,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [31:0] m1_rdata,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    input  logic [31:0] m1_awaddr,
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    output logic        m1_bvalid,
    input  logic        m1_bready,
    // slave
    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic        s_rvalid,
    output logic        s_rready,
    output logic [31:0] s_awaddr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_awvalid,
    output logic        s_wvalid,
    input  logic        s_awready,
    input  logic        s_wready,
    input  logic        s_bvalid,
    output logic        s_bready,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;

    state_t      state_q, state_d;
    logic        prio_q;
    logic        owner_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic req0, req1, wr0, wr1, sel, sel_rd, sel_wr;
    logic acc_rd, acc_wr, done;

    // A write only counts as a request once both address and data are offered.
    assign wr0    = m0_awvalid && m0_wvalid;
    assign wr1    = m1_awvalid && m1_wvalid;
    assign req0   = m0_arvalid || wr0;
    assign req1   = m1_arvalid || wr1;
    assign sel    = (req0 && req1) ? prio_q : req1;
    assign sel_rd = sel ? m1_arvalid : m0_arvalid;
    assign sel_wr = sel ? wr1 : wr0;

    always_comb begin
        state_d    = state_q;
        acc_rd     = 1'b0;
        acc_wr     = 1'b0;
        done       = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_awready = 1'b0;
        m1_awready = 1'b0;
        m0_wready  = 1'b0;
        m1_wready  = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_bvalid  = 1'b0;
        m1_bvalid  = 1'b0;
        s_arvalid  = 1'b0;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_rready   = 1'b0;
        s_bready   = 1'b0;
        case (state_q)
            IDLE: begin
                // Accepts are suppressed while rst is high so nothing is handshaken during reset.
                if (!rst && (req0 || req1)) begin
                    if (sel_rd) begin
                        acc_rd     = 1'b1;
                        m0_arready = !sel;
                        m1_arready = sel;
                        state_d    = RD_ADDR;
                    end else if (sel_wr) begin
                        acc_wr     = 1'b1;
                        m0_awready = !sel;
                        m0_wready  = !sel;
                        m1_awready = sel;
                        m1_wready  = sel;
                        state_d    = WR_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                m0_rvalid = !owner_q && s_rvalid;
                m1_rvalid = owner_q && s_rvalid;
                s_rready  = owner_q ? m1_rready : m0_rready;
                if (s_rvalid && s_rready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_ADDR: begin
                s_awvalid = 1'b1;
                s_wvalid  = 1'b1;
                if (s_awready && s_wready) state_d = WR_RESP;
            end
            WR_RESP: begin
                m0_bvalid = !owner_q && s_bvalid;
                m1_bvalid = owner_q && s_bvalid;
                s_bready  = owner_q ? m1_bready : m0_bready;
                if (s_bvalid && s_bready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= RESET_PRIO;
            owner_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            if (acc_rd) begin
                owner_q <= sel;
                addr_q  <= sel ? m1_araddr : m0_araddr;
            end
            if (acc_wr) begin
                owner_q <= sel;
                addr_q  <= sel ? m1_awaddr : m0_awaddr;
                wdata_q <= sel ? m1_wdata : m0_wdata;
                wstrb_q <= sel ? m1_wstrb : m0_wstrb;
            end
            // Priority always passes to the other master, requesting or not.
            if (done) prio_q <= !owner_q;
        end
    end

    assign s_araddr = addr_q;
    assign s_awaddr = addr_q;
    assign s_wdata  = wdata_q;
    assign s_wstrb  = wstrb_q;
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign busy     = (state_q != IDLE);
    assign grant    = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_axi_lite_arb2.sv
// Directed bench for axi_lite_arb2: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_axi_lite_arb2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_arvalid, m0_rready, m0_awvalid, m0_wvalid, m0_bready;
    logic        m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready;
    logic        m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid;
    logic        m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic        s_awvalid, s_wvalid, s_awready, s_wready, s_bvalid, s_bready;
    logic [1:0]  grant;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    axi_lite_arb2 #(.RESET_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_awvalid(s_awvalid), .s_wvalid(s_wvalid), .s_awready(s_awready), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        {m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata} = '0;
        {m0_wstrb, m1_wstrb} = '0;
        {m0_arvalid, m0_rready, m0_awvalid, m0_wvalid, m0_bready} = '0;
        {m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready} = '0;
        s_rdata = '0;
        {s_arready, s_rvalid, s_awready, s_wready, s_bvalid} = '0;
    endtask

    task automatic test_reset();
        logic [14:0] hs;
        rst = 1'b1;
        {m0_araddr, m1_araddr, m0_awaddr, m1_awaddr, m0_wdata, m1_wdata} = '1;
        {m0_wstrb, m1_wstrb} = '1;
        {m0_arvalid, m0_rready, m0_awvalid, m0_wvalid, m0_bready} = '1;
        {m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready} = '1;
        s_rdata = '1;
        {s_arready, s_rvalid, s_awready, s_wready, s_bvalid} = '1;
        cyc();
        cyc();
        smp();
        hs = {m0_arready, m0_awready, m0_wready, m0_rvalid, m0_bvalid,
              m1_arready, m1_awready, m1_wready, m1_rvalid, m1_bvalid,
              s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready};
        n_tests++;
        if (hs !== 15'h0) begin n_fail++; $display("FAIL reset_handshakes: got %h want 0000", hs); end
        n_tests++;
        if ({grant, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_grant_busy: got %b want 000", {grant, busy}); end
        n_tests++;
        if ({s_araddr, s_wdata, s_wstrb} !== 68'h0) begin n_fail++; $display("FAIL reset_latches: got %h want 0", {s_araddr, s_wdata, s_wstrb}); end
        idle_inputs();
        rst = 1'b0;
        cyc();
    endtask

    // prio=0 after reset: M0 read is served before the simultaneous M1 write.
    task automatic test_contention();
        m0_araddr = 32'h300; m0_arvalid = 1'b1; m0_rready = 1'b1;
        m1_awaddr = 32'h200; m1_wdata = 32'h5A; m1_wstrb = 4'hF;
        m1_awvalid = 1'b1; m1_wvalid = 1'b1; m1_bready = 1'b1;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        smp();
        n_tests++;
        if ({m0_arready, m1_arready, m1_awready, m1_wready} !== 4'b1000) begin
            n_fail++; $display("FAIL contention_first_accept: got %b want 1000", {m0_arready, m1_arready, m1_awready, m1_wready}); end
        cyc(); m0_arvalid = 1'b0;
        smp();
        n_tests++;
        if ({s_arvalid, s_araddr, grant, m1_awready} !== {1'b1, 32'h300, 2'b01, 1'b0}) begin
            n_fail++; $display("FAIL contention_rd_addr: got %b %h %b %b", s_arvalid, s_araddr, grant, m1_awready); end
        cyc(); s_rvalid = 1'b1; s_rdata = 32'h1111_2222;
        smp();
        n_tests++;
        if ({m0_rvalid, m0_rdata, m1_rvalid, s_rready} !== {1'b1, 32'h1111_2222, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL contention_rd_data: got %b %h %b %b", m0_rvalid, m0_rdata, m1_rvalid, s_rready); end
        cyc(); s_rvalid = 1'b0;
        smp();
        n_tests++;
        if ({m1_awready, m1_wready, busy} !== 3'b110) begin
            n_fail++; $display("FAIL contention_wr_accept: got %b want 110", {m1_awready, m1_wready, busy}); end
        cyc(); m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        smp();
        n_tests++;
        if ({s_awvalid, s_wvalid, s_awaddr, s_wdata, s_wstrb, grant} !== {2'b11, 32'h200, 32'h5A, 4'hF, 2'b10}) begin
            n_fail++; $display("FAIL contention_wr_addr: got %b%b %h %h %h %b", s_awvalid, s_wvalid, s_awaddr, s_wdata, s_wstrb, grant); end
        cyc(); s_bvalid = 1'b1;
        smp();
        n_tests++;
        if ({m1_bvalid, m0_bvalid, s_bready} !== 3'b101) begin
            n_fail++; $display("FAIL contention_wr_resp: got %b want 101", {m1_bvalid, m0_bvalid, s_bready}); end
        cyc(); s_bvalid = 1'b0;
        // Probe prio: both request, M0 should win, then withdraw before the edge.
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        smp();
        n_tests++;
        if ({busy, m0_arready, m1_arready} !== 3'b010) begin
            n_fail++; $display("FAIL contention_prio_end: got %b want 010", {busy, m0_arready, m1_arready}); end
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        cyc();
        idle_inputs();
    endtask

    task automatic test_single_read();
        m0_araddr = 32'h0000_0104; m0_arvalid = 1'b1; m0_rready = 1'b1; s_arready = 1'b1;
        smp();
        n_tests++;
        if ({m0_arready, m1_arready, m1_awready, m1_wready, m1_rvalid, m1_bvalid} !== 6'b100000) begin
            n_fail++; $display("FAIL single_accept: got %b want 100000", {m0_arready, m1_arready, m1_awready, m1_wready, m1_rvalid, m1_bvalid}); end
        cyc(); m0_arvalid = 1'b0;
        smp();
        n_tests++;
        if ({s_arvalid, s_araddr, busy} !== {1'b1, 32'h104, 1'b1}) begin
            n_fail++; $display("FAIL single_s_ar: got %b %h %b", s_arvalid, s_araddr, busy); end
        cyc(); s_arready = 1'b0;
        smp();
        n_tests++;
        if ({m0_rvalid, s_arvalid} !== 2'b00) begin
            n_fail++; $display("FAIL single_wait: got %b want 00", {m0_rvalid, s_arvalid}); end
        cyc(); s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        smp();
        n_tests++;
        if ({m0_rvalid, m0_rdata, m1_rvalid, m1_arready, m1_awready, m1_wready, m1_bvalid} !== {1'b1, 32'hDEAD_BEEF, 5'b0}) begin
            n_fail++; $display("FAIL single_rdata: got %b %h m1=%b", m0_rvalid, m0_rdata, {m1_rvalid, m1_arready, m1_awready, m1_wready, m1_bvalid}); end
        cyc(); s_rvalid = 1'b0;
        smp();
        n_tests++;
        if ({grant, busy} !== 3'b000) begin n_fail++; $display("FAIL single_done: got %b want 000", {grant, busy}); end
        cyc();
        idle_inputs();
    endtask

    // prio=1 here, so the accept order must be M1, M0, M1, M0.
    task automatic test_fairness();
        int seq[8];
        int cnt = 0;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
        s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0F0F_0F0F;
        for (int c = 0; c < 12; c++) begin
            smp();
            if (m0_arready && cnt < 8) begin seq[cnt] = 0; cnt++; end
            if (m1_arready && cnt < 8) begin seq[cnt] = 1; cnt++; end
            cyc();
        end
        idle_inputs();
        n_tests++;
        if (cnt !== 4) begin n_fail++; $display("FAIL fairness_count: got %0d want 4", cnt); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= cnt || seq[i] !== ((i % 2 == 0) ? 1 : 0)) begin
                n_fail++; $display("FAIL fairness_order[%0d]: got %0d want %0d", i, (i < cnt) ? seq[i] : -1, (i % 2 == 0) ? 1 : 0); end
        end
        cyc();
    endtask

    task automatic test_backpressure();
        m1_araddr = 32'h0000_0044; m1_arvalid = 1'b1;
        smp();
        n_tests++;
        if ({m1_arready, m0_arready} !== 2'b10) begin n_fail++; $display("FAIL bp_accept: got %b want 10", {m1_arready, m0_arready}); end
        cyc(); m1_arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            smp();
            n_tests++;
            if ({s_arvalid, s_araddr, grant} !== {1'b1, 32'h44, 2'b10}) begin
                n_fail++; $display("FAIL bp_ar_stall[%0d]: got %b %h %b", c, s_arvalid, s_araddr, grant); end
            cyc();
        end
        s_arready = 1'b1;
        cyc(); s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0000_CAFE;
        for (int c = 0; c < 3; c++) begin
            smp();
            n_tests++;
            if ({m1_rvalid, s_rready, busy, s_arvalid} !== 4'b1010) begin
                n_fail++; $display("FAIL bp_r_stall[%0d]: got %b want 1010", c, {m1_rvalid, s_rready, busy, s_arvalid}); end
            cyc();
        end
        m1_rready = 1'b1;
        smp();
        n_tests++;
        if ({m1_rvalid, m1_rdata, s_rready} !== {1'b1, 32'h0000_CAFE, 1'b1}) begin
            n_fail++; $display("FAIL bp_r_done: got %b %h %b", m1_rvalid, m1_rdata, s_rready); end
        cyc(); s_rvalid = 1'b0; m1_rready = 1'b0;
        smp();
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b want 0", busy); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_reset_mid_write();
        m1_awaddr = 32'h0000_0300; m1_wdata = 32'hAAAA_5555; m1_wstrb = 4'hC;
        m1_awvalid = 1'b1; m1_wvalid = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        cyc(); m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        cyc(); s_bvalid = 1'b1;
        smp();
        n_tests++;
        if ({m1_bvalid, grant} !== 3'b110) begin n_fail++; $display("FAIL rmw_in_resp: got %b want 110", {m1_bvalid, grant}); end
        rst = 1'b1;
        cyc(); rst = 1'b0;
        smp();
        n_tests++;
        if ({m1_bvalid, s_bready, busy, grant} !== 5'b0) begin
            n_fail++; $display("FAIL rmw_after_reset: got %b want 00000", {m1_bvalid, s_bready, busy, grant}); end
        n_tests++;
        if ({s_awaddr, s_wdata, s_wstrb} !== 68'h0) begin n_fail++; $display("FAIL rmw_latch_cleared: got %h want 0", {s_awaddr, s_wdata, s_wstrb}); end
        cyc(); s_bvalid = 1'b0;
        m1_awaddr = 32'h0000_0080; m1_wdata = 32'h1234_5678; m1_wstrb = 4'h3;
        m1_awvalid = 1'b1; m1_wvalid = 1'b1; m1_bready = 1'b1;
        smp();
        n_tests++;
        if ({m1_awready, m1_wready} !== 2'b11) begin n_fail++; $display("FAIL rmw_new_accept: got %b want 11", {m1_awready, m1_wready}); end
        cyc(); m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        smp();
        n_tests++;
        if ({s_awvalid, s_awaddr, s_wdata, s_wstrb} !== {1'b1, 32'h80, 32'h1234_5678, 4'h3}) begin
            n_fail++; $display("FAIL rmw_new_aw: got %b %h %h %h", s_awvalid, s_awaddr, s_wdata, s_wstrb); end
        cyc(); s_bvalid = 1'b1;
        smp();
        n_tests++;
        if ({m1_bvalid, s_bready} !== 2'b11) begin n_fail++; $display("FAIL rmw_new_b: got %b want 11", {m1_bvalid, s_bready}); end
        cyc(); s_bvalid = 1'b0;
        smp();
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rmw_new_done: got %b want 0", busy); end
        cyc();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_read();
        test_fairness();
        test_backpressure();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
